// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: PC control codes, instruction field layout,
// opcode/ALU constants used by the controller, and the fetch FSM state type.
package cpu_pkg;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;
  localparam logic [1:0] PC_CLR  = 2'b11;

  localparam int unsigned OPCODE_LSB = 12;
  localparam int unsigned OPCODE_W   = 4;
  localparam int unsigned RD_LSB     = 10;
  localparam int unsigned RD_W       = 2;
  localparam int unsigned RS_LSB     = 8;
  localparam int unsigned RS_W       = 2;
  localparam int unsigned OFFSET_LSB = 0;
  localparam int unsigned OFFSET_W   = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ALU  = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_BEQ  = 4'h5;
  localparam logic [3:0] OP_BNE  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU function select, carried in the low bits of the offset field for OP_ALU.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;
  localparam logic [2:0] ALU_MOV = 3'd7;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitAck = 2'd1,
    StLoaded  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter: applies the controller's pc_ctrl code on each en_pc_pulse.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_pc_pulse,
  input  logic [1:0]        pc_ctrl,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d;

  // Increment wraps naturally at 2^ADDR_W.
  always_comb begin
    pc_d = pc;
    if (en_pc_pulse) begin
      unique case (pc_ctrl)
        PC_HOLD: pc_d = pc;
        PC_INC:  pc_d = pc + ADDR_W'(1);
        PC_LOAD: pc_d = load_val;
        PC_CLR:  pc_d = '0;
        default: pc_d = pc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else begin
      pc <= pc_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR, fetches words over a req/ack handshake and presents
// the decoded instruction fields to the controller.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_fetch_pulse,
  input  logic               en_pc_pulse,
  input  logic [1:0]         pc_ctrl,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               ir_valid,
  output logic [3:0]         opcode,
  output logic [1:0]         rd,
  output logic [1:0]         rs,
  output logic [7:0]         offset,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               fetch_err
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  jump_target;
  logic               busy;

  assign busy        = (state_q == StWaitAck);
  assign jump_target = ADDR_W'(ir_q[OFFSET_LSB +: OFFSET_W]);

  pc_reg #(
    .ADDR_W(ADDR_W)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .en_pc_pulse (en_pc_pulse),
    .pc_ctrl     (pc_ctrl),
    .load_val    (jump_target),
    .pc          (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // LOADED behaves like IDLE for a new fetch so back-to-back fetches lose no cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StLoaded: state_d = en_fetch_pulse ? StWaitAck : StIdle;
      StWaitAck:        state_d = mem_ack ? StLoaded : StWaitAck;
      default:          state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req  = (state_q == StWaitAck);
    ir_valid = (state_q == StLoaded);
  end

  // Address captures the PC before any same-cycle PC update.
  always_comb begin
    ir_d   = ir_q;
    addr_d = addr_q;
    err_d  = err_q;
    if (busy) begin
      if (mem_ack) ir_d = mem_rdata;
      if (en_fetch_pulse) err_d = 1'b1;
    end else if (en_fetch_pulse) begin
      addr_d = pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q   <= '0;
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ir_q   <= ir_d;
      addr_q <= addr_d;
      err_q  <= err_d;
    end
  end

  assign mem_addr  = addr_q;
  assign pc_out    = pc;
  assign fetch_err = err_q;
  assign opcode    = ir_q[OPCODE_LSB +: OPCODE_W];
  assign rd        = ir_q[RD_LSB +: RD_W];
  assign rs        = ir_q[RS_LSB +: RS_W];
  assign offset    = ir_q[OFFSET_LSB +: OFFSET_W];

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch stage directly upstream of the control state machine: owns the program counter and instruction register, and fetches instruction words from program memory over a req/ack handshake. It consumes `en_fetch_pulse`, `en_pc_pulse` and `pc_ctrl` from the controller, and returns `ir_valid` (the controller's IR-ready input) plus the decoded `opcode`/`rd` fields. Jump targets come from the offset field of the instruction it holds.

## Interface
- `ADDR_W`, default 8: PC and memory address width.
- `INSTR_W`, default 16: instruction width; format opcode[15:12], rd[11:10], rs[9:8], offset[7:0].

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en_fetch_pulse`  in  1  one-cycle request to fetch the instruction at the current PC.
- `en_pc_pulse`  in  1  one-cycle PC update strobe.
- `pc_ctrl`  in  2  00 hold, 01 PC+1, 10 load offset, 11 clear to 0.
- `mem_req`  out  1  read request to program memory.
- `mem_addr`  out  ADDR_W  read address; stable while `mem_req`=1.
- `mem_ack`  in  1  read data valid.
- `mem_rdata`  in  INSTR_W  instruction word.
- `ir_valid`  out  1  one-cycle pulse when the IR has been loaded.
- `opcode`  out  4  IR[15:12].
- `rd`  out  2  IR[11:10].
- `rs`  out  2  IR[9:8].
- `offset`  out  8  IR[7:0].
- `pc_out`  out  ADDR_W  current PC.
- `fetch_err`  out  1  sticky: a fetch request was dropped because the unit was busy.

## Operation
- Reset values: `pc`=0, `ir`=0 (so all field outputs are 0), `mem_req`=0, `mem_addr`=0, `ir_valid`=0, `fetch_err`=0, FSM in IDLE.
- FSM states: IDLE, WAIT_ACK, LOADED.
  - IDLE: on `en_fetch_pulse`, latch `mem_addr` <= `pc` (value before any same-cycle PC update), go to WAIT_ACK.
  - WAIT_ACK: `mem_req`=1. On `mem_ack`, `ir` <= `mem_rdata`, go to LOADED. There is no timeout.
  - LOADED: `ir_valid`=1 for exactly this cycle, `mem_req`=0, then return to IDLE. An `en_fetch_pulse` arriving in LOADED is accepted as if the FSM were in IDLE.
- `en_fetch_pulse` in WAIT_ACK is ignored and sets `fetch_err`. Only `rst` clears `fetch_err`.
- PC update on `en_pc_pulse`, independent of FSM state:
  - 01: `pc`+1, wrapping from 2^ADDR_W−1 to 0.
  - 10: `pc` <= `offset`, zero-extended or truncated to ADDR_W, using the IR contents of that cycle.
  - 11: `pc` <= 0.
  - 00: hold.
- Simultaneous `en_fetch_pulse` and `en_pc_pulse`: the fetch uses the old PC and the PC updates. This is the controller's normal Fetch entry.
- `mem_ack` outside WAIT_ACK is ignored.
- `rst` mid-fetch: `mem_req` drops immediately (asynchronous), the IR is cleared, and the late `mem_ack` is ignored.

## Timing
- `en_fetch_pulse` at edge T: `mem_req`=1 from T+1.
- `mem_ack` sampled high at edge A: IR is updated at A. During A+1, `ir_valid`=1 and `mem_req`=0.
- Minimum latency (ack in the first request cycle): `en_fetch_pulse` at T gives `ir_valid` at T+2.
- Field outputs change only at the IR load edge. They are combinational slices of the IR.
- The PC updates at the edge where `en_pc_pulse` is sampled; `pc_out` shows the new value the cycle after.

## Structure
- Shared package `cpu_pkg` holds:
  - `pc_ctrl` encodings: PC_HOLD, PC_INC, PC_LOAD, PC_CLR.
  - IR field bit positions and widths: opcode, rd, rs, offset.
  - Opcode and ALU function constants used by the controller.
  - The FSM state enum.
- One natural sub-module: `pc_reg`, which holds the program counter, applies `pc_ctrl` on `en_pc_pulse`, and handles wrap-around. The FSM, IR and field slicing stay in the top level.

## Test plan
- Reset: assert `rst` with random inputs → all outputs 0; release and idle 5 cycles → no `mem_req`.
- Basic fetch: PC=0, `en_fetch_pulse` together with `en_pc_pulse`/01; memory acks after 3 cycles with 0x2C05 → `mem_addr`=0, `ir_valid` one cycle after the ack; then `opcode`=2, `rd`=3, `rs`=0, `offset`=0x05, `pc_out`=1.
- Jump: IR=0x7012, `en_pc_pulse`/10 → `pc_out`=0x12. Next fetch → `mem_addr`=0x12.
- Wrap and clear: PC=0xFF with `en_pc_pulse`/01 → 0x00. `pc_ctrl`=11 from 0x40 → 0x00.
- Busy and error: second `en_fetch_pulse` during WAIT_ACK → no new request, `fetch_err`=1 and sticky; the original fetch completes normally.
- Reset mid-fetch: `rst` in WAIT_ACK, then `mem_ack` with 0xFFFF → IR stays 0, no `ir_valid`.
